hashing_pll_supervisor: RTL and testbench

- Sequences and monitors the hashing PLL from the reference-clock side: drives the PLL's active-high asynchronous reset and consumes its `lock` output.
- Qualifies lock for a stable interval before declaring the hash clocks usable, and re-initialises the PLL on lock loss, lock timeout or software request.
- Sits in the `rx_clk` (board reference) domain, alongside the PLL.
- Its `tx_ready` gates release of the hashing-core resets.

---
 rtl/hashing_pll_supervisor_if.sv | 32 +++
 rtl/hashing_pll_supervisor.sv | 112 +++++++++++
 tb/tb_hashing_pll_supervisor.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hashing_pll_supervisor_if.sv
// rtl/hashing_pll_supervisor_if.sv - lock/restart inputs and status outputs of the PLL supervisor
//
// Purpose: bundles the supervisor's non-clock signals.
//   rx_lock          PLL lock, asynchronous to rx_clk
//   rx_restart       single-cycle software re-initialise request
//   tx_pll_areset    PLL areset, active high
//   tx_ready         hash clocks qualified
//   tx_state         current supervisor state
//   tx_relock_count  saturating count of lock losses in RUN
//   tx_timeout_count saturating count of WAIT_LOCK timeouts
// master: the side that drives lock/restart; slave: the supervisor.
interface hashing_pll_supervisor_if #(
    parameter int COUNT_WIDTH = 8
);
    logic                   rx_lock;
    logic                   rx_restart;
    logic                   tx_pll_areset;
    logic                   tx_ready;
    logic [1:0]             tx_state;
    logic [COUNT_WIDTH-1:0] tx_relock_count;
    logic [COUNT_WIDTH-1:0] tx_timeout_count;

    modport master (
        output rx_lock, rx_restart,
        input  tx_pll_areset, tx_ready, tx_state, tx_relock_count, tx_timeout_count
    );

    modport slave (
        input  rx_lock, rx_restart,
        output tx_pll_areset, tx_ready, tx_state, tx_relock_count, tx_timeout_count
    );
endinterface

// File: rtl/hashing_pll_supervisor.sv
// rtl/hashing_pll_supervisor.sv - hashing PLL reset sequencer and lock qualifier
//
// Purpose: holds the PLL in reset, waits for lock, qualifies it for a stable
// interval, then raises tx_ready. Lock loss, lock timeout or rx_restart
// re-initialise the PLL.
// Ports:
//   rx_clk      board reference clock
//   rx_reset_n  asynchronous active-low reset
//   bus         hashing_pll_supervisor_if slave (lock/restart in, status out)
module hashing_pll_supervisor #(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int COUNT_WIDTH   = 8
) (
    input  logic                     rx_clk,
    input  logic                     rx_reset_n,
    hashing_pll_supervisor_if.slave  bus
);
    localparam int MAX_AB = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_C  = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CW-1:0] RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lock_m, lock_s;
    logic                   areset_q, ready_q;
    logic [COUNT_WIDTH-1:0] relock_q, timeout_q;
    logic                   relock_inc, timeout_inc;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        relock_inc  = 1'b0;
        timeout_inc = 1'b0;
        if (bus.rx_restart) begin
            // Restart beats every other transition and also restarts the
            // reset interval when already in RESET_PLL.
            state_d = RESET_PLL;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                RESET_PLL: begin
                    if (cnt_q == RESET_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    // Lock arriving on the timeout cycle wins.
                    if (lock_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d     = RESET_PLL;
                        timeout_inc = 1'b1;
                    end
                end
                STABLE: begin
                    if (!lock_s)                  state_d = WAIT_LOCK;
                    else if (cnt_q == STABLE_LAST) state_d = RUN;
                end
                RUN: begin
                    cnt_d = cnt_q;
                    if (!lock_s) begin
                        state_d    = RESET_PLL;
                        relock_inc = 1'b1;
                    end
                end
                default: state_d = RESET_PLL;
            endcase
            if (state_d != state_q) cnt_d = '0;
        end
    end

    always_ff @(posedge rx_clk or negedge rx_reset_n) begin
        if (!rx_reset_n) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            state_q   <= RESET_PLL;
            cnt_q     <= '0;
            areset_q  <= 1'b1;
            ready_q   <= 1'b0;
            relock_q  <= '0;
            timeout_q <= '0;
        end else begin
            lock_m   <= bus.rx_lock;
            lock_s   <= lock_m;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            // Outputs are decoded from the next state so they change on the
            // same edge as the state register.
            areset_q <= (state_d == RESET_PLL);
            ready_q  <= (state_d == RUN);
            if (relock_inc && (relock_q != '1))   relock_q  <= relock_q + 1'b1;
            if (timeout_inc && (timeout_q != '1)) timeout_q <= timeout_q + 1'b1;
        end
    end

    assign bus.tx_pll_areset    = areset_q;
    assign bus.tx_ready         = ready_q;
    assign bus.tx_state         = state_q;
    assign bus.tx_relock_count  = relock_q;
    assign bus.tx_timeout_count = timeout_q;
endmodule

// File: tb/tb_hashing_pll_supervisor.sv
// tb/tb_hashing_pll_supervisor.sv - self-checking bench for hashing_pll_supervisor
module tb_hashing_pll_supervisor;
    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int CWID = 2;
    localparam int SAT = (1 << CWID) - 1;

    logic rx_clk = 1'b0;
    logic rx_reset_n;

    hashing_pll_supervisor_if #(.COUNT_WIDTH(CWID)) bus();

    hashing_pll_supervisor #(
        .RESET_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .COUNT_WIDTH(CWID)
    ) dut (
        .rx_clk(rx_clk),
        .rx_reset_n(rx_reset_n),
        .bus(bus)
    );

    always #5 rx_clk = ~rx_clk;

    int total = 0;
    int passed = 0;

    // Reference model: phase number, edge on which the phase was entered,
    // and a history of sampled lock values (the FSM acts on the sample taken
    // two edges earlier).
    int m_edge, m_enter, m_phase, m_relock, m_tout;
    int lock_hist[$];

    function automatic void model_reset();
        m_edge = 0; m_enter = 0; m_phase = 0; m_relock = 0; m_tout = 0;
        lock_hist.delete();
    endfunction

    function automatic void model_step(input int l, input int r);
        int seen, spent, nxt;
        m_edge++;
        seen  = (lock_hist.size() >= 2) ? lock_hist[lock_hist.size() - 2] : 0;
        spent = m_edge - m_enter;
        nxt   = m_phase;
        if (r != 0) begin
            nxt = 0;
            m_enter = m_edge;
        end else begin
            case (m_phase)
                0: if (spent == RC) nxt = 1;
                1: if (seen != 0) nxt = 2;
                   else if (spent == LT) begin nxt = 0; if (m_tout < SAT) m_tout++; end
                2: if (seen == 0) nxt = 1;
                   else if (spent == SC) nxt = 3;
                default: if (seen == 0) begin nxt = 0; if (m_relock < SAT) m_relock++; end
            endcase
        end
        if (nxt != m_phase) m_enter = m_edge;
        m_phase = nxt;
        lock_hist.push_back(l);
        if (lock_hist.size() > 4) void'(lock_hist.pop_front());
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_model();
        chk("model_state",   int'(bus.tx_state),         m_phase);
        chk("model_areset",  int'(bus.tx_pll_areset),    (m_phase == 0) ? 1 : 0);
        chk("model_ready",   int'(bus.tx_ready),         (m_phase == 3) ? 1 : 0);
        chk("model_relock",  int'(bus.tx_relock_count),  m_relock);
        chk("model_timeout", int'(bus.tx_timeout_count), m_tout);
    endtask

    task automatic step(input logic l, input logic r);
        bus.rx_lock    = l;
        bus.rx_restart = r;
        @(posedge rx_clk);
        model_step(int'(l), int'(r));
        #1;
        bus.rx_restart = 1'b0;
        chk_model();
    endtask

    task automatic wait_state(input int target, input logic l, input int budget);
        int n = 0;
        while (int'(bus.tx_state) != target && n < budget) begin
            step(l, 1'b0);
            n++;
        end
        chk("wait_state_bound", int'(bus.tx_state), target);
    endtask

    typedef struct {
        logic lock;
        int   n;
        int   st;
        int   ar;
        int   rd;
        int   rel;
        int   to;
    } vec_t;

    vec_t tbl[8];

    initial begin
        // Power-up then loss in RUN, hand-derived edge by edge.
        tbl[0] = '{1'b0, 3, 0, 1, 0, 0, 0};
        tbl[1] = '{1'b0, 1, 1, 0, 0, 0, 0};
        tbl[2] = '{1'b0, 6, 1, 0, 0, 0, 0};
        tbl[3] = '{1'b1, 2, 1, 0, 0, 0, 0};
        tbl[4] = '{1'b1, 1, 2, 0, 0, 0, 0};
        tbl[5] = '{1'b1, 7, 2, 0, 0, 0, 0};
        tbl[6] = '{1'b1, 1, 3, 0, 1, 0, 0};
        tbl[7] = '{1'b0, 2, 3, 0, 1, 0, 0};

        rx_reset_n     = 1'b0;
        bus.rx_lock    = 1'b0;
        bus.rx_restart = 1'b0;
        model_reset();
        repeat (2) @(posedge rx_clk);
        #1;
        chk("reset_state",   int'(bus.tx_state), 0);
        chk("reset_areset",  int'(bus.tx_pll_areset), 1);
        chk("reset_ready",   int'(bus.tx_ready), 0);
        chk("reset_relock",  int'(bus.tx_relock_count), 0);
        chk("reset_timeout", int'(bus.tx_timeout_count), 0);
        rx_reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < tbl[i].n; j++) step(tbl[i].lock, 1'b0);
            chk($sformatf("tbl%0d_state", i),  int'(bus.tx_state), tbl[i].st);
            chk($sformatf("tbl%0d_areset", i), int'(bus.tx_pll_areset), tbl[i].ar);
            chk($sformatf("tbl%0d_ready", i),  int'(bus.tx_ready), tbl[i].rd);
            chk($sformatf("tbl%0d_relock", i), int'(bus.tx_relock_count), tbl[i].rel);
            chk($sformatf("tbl%0d_tout", i),   int'(bus.tx_timeout_count), tbl[i].to);
        end
        step(1'b0, 1'b0);
        chk("loss_state",  int'(bus.tx_state), 0);
        chk("loss_areset", int'(bus.tx_pll_areset), 1);
        chk("loss_ready",  int'(bus.tx_ready), 0);
        chk("loss_relock", int'(bus.tx_relock_count), 1);

        // Never lock: four full rounds, timeout counter saturates at 3.
        for (int r = 1; r <= 4; r++) begin
            repeat (RC) step(1'b0, 1'b0);
            chk("nolock_wait", int'(bus.tx_state), 1);
            repeat (LT - 1) step(1'b0, 1'b0);
            chk("nolock_pre", int'(bus.tx_timeout_count), (r - 1 > SAT) ? SAT : r - 1);
            step(1'b0, 1'b0);
            chk("nolock_state", int'(bus.tx_state), 0);
            chk("nolock_count", int'(bus.tx_timeout_count), (r > SAT) ? SAT : r);
        end

        // Lock bounce in STABLE.
        wait_state(2, 1'b1, 40);
        repeat (4) step(1'b1, 1'b0);
        repeat (2) step(1'b0, 1'b0);
        chk("bounce_still_stable", int'(bus.tx_state), 2);
        step(1'b1, 1'b0);
        chk("bounce_wait", int'(bus.tx_state), 1);
        chk("bounce_areset", int'(bus.tx_pll_areset), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        chk("bounce_restable", int'(bus.tx_state), 2);
        repeat (SC - 1) step(1'b1, 1'b0);
        chk("bounce_full_stable", int'(bus.tx_state), 2);
        step(1'b1, 1'b0);
        chk("bounce_run", int'(bus.tx_state), 3);
        chk("bounce_relock", int'(bus.tx_relock_count), 1);

        // Repeated loss in RUN: relock counter saturates.
        for (int k = 0; k < 4; k++) begin
            wait_state(3, 1'b1, 40);
            repeat (2) step(1'b0, 1'b0);
            chk("rep_ready_hold", int'(bus.tx_ready), 1);
            step(1'b0, 1'b0);
            chk("rep_ready", int'(bus.tx_ready), 0);
            chk("rep_areset", int'(bus.tx_pll_areset), 1);
            chk("rep_relock", int'(bus.tx_relock_count), (k + 2 > SAT) ? SAT : k + 2);
        end

        // Restart collides with lock loss in RUN: not counted. Counter is
        // saturated here, so clear it first with a reset to make it visible.
        rx_reset_n = 1'b0;
        #1;
        model_reset();
        rx_reset_n = 1'b1;
        wait_state(3, 1'b1, 60);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        chk("collide_state", int'(bus.tx_state), 0);
        chk("collide_relock", int'(bus.tx_relock_count), 0);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        repeat (RC - 1) step(1'b0, 1'b0);
        chk("restart_ext_areset", int'(bus.tx_pll_areset), 1);
        step(1'b0, 1'b0);
        chk("restart_ext_release", int'(bus.tx_pll_areset), 0);

        // Asynchronous reset mid-RUN.
        wait_state(3, 1'b1, 60);
        repeat (2) step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        wait_state(3, 1'b1, 60);
        #2;
        rx_reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_ready",   int'(bus.tx_ready), 0);
        chk("async_areset",  int'(bus.tx_pll_areset), 1);
        chk("async_relock",  int'(bus.tx_relock_count), 0);
        chk("async_timeout", int'(bus.tx_timeout_count), 0);
        chk("async_state",   int'(bus.tx_state), 0);
        @(posedge rx_clk);
        #1;
        rx_reset_n = 1'b1;

        // Randomized segments against the model.
        for (int s = 0; s < 120; s++) begin
            logic l;
            int len;
            l   = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 9) == 0) ? 1 : $urandom_range(1, 40);
            for (int c = 0; c < len; c++)
                step(l, ($urandom_range(0, 63) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
